gen1_lane_scrambler: RTL
========================

# gen1_lane_scrambler

Parametrised PCIe Gen1/Gen2 (8b/10b) byte scrambler with its own LFSR. It processes NUM_BYTES symbols per clock, with byte 0 earliest in time. The block replaces the earlier split of external per-byte LFSR values plus a combinational XOR stage with a single registered block. It sits between the link-layer TX datapath and the 8b/10b encoder. Since scrambling is an XOR, the same block also serves as the RX descrambler after the 8b/10b decoder.

## Interface
Parameters:
- NUM_BYTES, 4: symbols per cycle; legal values 1, 2, 4, 8.
- SEED, 16'hFFFF: LFSR value loaded on reset and after every COM.

Ports:
- clk_i, input, 1: sole clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- valid_i, input, 1: input beat valid.
- data_i, input, 8*NUM_BYTES: symbols; byte j is data_i[8j+7:8j].
- datak_i, input, NUM_BYTES: per-byte K flag.
- training_sequence_i, input, NUM_BYTES: per-byte TS flag; the byte advances the LFSR but is not scrambled.
- scramble_enable_i, input, 1: 0 means all bytes pass through unscrambled.
- valid_o, output, 1: output beat valid.
- data_o, output, 8*NUM_BYTES: scrambled symbols.
- datak_o, output, NUM_BYTES: datak_i delayed to align with data_o.
- lfsr_o, output, 16: LFSR state after the last accepted beat (debug).

## Operation
- LFSR:
  - Polynomial is x^16+x^5+x^4+x^3+1, Galois form.
  - Per bit: the scramble bit is l[15].
  - Next state is {l[14:0],1'b0} ^ (l[15] ? 16'h0039 : 0).
- Byte handling, in order from byte 0 to byte NUM_BYTES-1, within a single cycle; each byte sees the state left by the previous byte:
  - COM (datak=1, data=8'hBC): byte passes unscrambled; the LFSR is loaded with SEED (no advance).
  - SKP (datak=1, data=8'h1C): byte passes unscrambled; the LFSR holds.
  - Other K symbol: byte passes unscrambled; the LFSR advances 8 bits.
  - Data byte: the LFSR advances 8 bits; the byte is scrambled unless its training_sequence_i bit is 1 or scramble_enable_i is 0.
- Scrambled byte bit b (0..7) is data bit b XORed with the scramble bit at step b. Bit 0 uses the oldest LFSR bit.
- scramble_enable_i=0 does not stop LFSR advance, COM reload or SKP hold. Only the XOR is suppressed.
- valid_i=0: the LFSR holds, valid_o goes to 0 next cycle, and data_o/datak_o hold their last values.
- Multiple COMs in one beat: the last COM wins. Bytes after it start from SEED.

## Timing
- Latency: 1 cycle. Outputs are registered; valid_o(t+1)=valid_i(t).
- There is no backpressure. One beat is accepted on every cycle with valid_i=1.
- Reset, asynchronous, takes effect immediately:
  - valid_o=0, data_o=0, datak_o=0.
  - LFSR=SEED, so lfsr_o=SEED.
- Reset mid-stream drops any in-flight beat. The first beat after reset uses SEED, whether or not a COM is present.
- lfsr_o updates in the same edge as data_o.
- Combinational depth is NUM_BYTES×8 LFSR steps. The implementation unrolls these as a chain within one cycle.

## Configuration
- GEN1_SCR_STATS_EN, defined:
  - Adds output com_count_o[15:0], which counts COM symbols accepted (several per beat allowed).
  - The count saturates at 16'hFFFF.
  - It resets to 0 and has the same 1-cycle latency as data_o.
- GEN1_SCR_STATS_EN, undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Golden sequence, NUM_BYTES=4:
  - Stimulus: a COM, then 16 data bytes of 8'h00 with enable=1.
  - Required response: FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 BE 6D BF 8D.
- SKP hold: insert an SKP between golden bytes 4 and 5. The SKP passes unscrambled as 8'h1C, and the following bytes still continue with E7 02 ...
- TS and disable:
  - TS flag on bytes 1–2: those bytes are output unscrambled, yet byte 3 equals golden byte 3 (14 for zero data).
  - scramble_enable_i=0 for a whole beat: data passes through and lfsr_o matches the enabled run.
- Mid-beat COM and valid gap:
  - COM in byte 2 of a beat: byte 3 scrambles with SEED and yields FF for 00 data.
  - valid_i=0 for 3 cycles: valid_o=0 for those 3 cycles and the LFSR is unchanged.
- Async reset mid-stream:
  - Assert rst_i between clock edges: outputs and lfsr_o clear immediately to 0 and FFFF.
  - The first post-reset beat of 00 data yields FF 17 C0 14 with no COM.
- Self-inverse check: two instances in series (scramble, then descramble) on 1000 random beats with random K/TS flags. Output equals input every beat, with 2-cycle latency.

Source files
------------

// File: rtl/gen1_lane_scrambler.sv
// PCIe Gen1/Gen2 (8b/10b) lane scrambler/descrambler with its own Galois LFSR, NUM_BYTES symbols per clock.
// Optional build macro GEN1_SCR_STATS_EN adds a saturating COM counter output (com_count_o).
module gen1_lane_scrambler #(
  parameter int unsigned NUM_BYTES = 4,
  parameter logic [15:0] SEED      = 16'hFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [8*NUM_BYTES-1:0] data_i,
  input  logic [NUM_BYTES-1:0]   datak_i,
  input  logic [NUM_BYTES-1:0]   training_sequence_i,
  input  logic                   scramble_enable_i,
  output logic                   valid_o,
  output logic [8*NUM_BYTES-1:0] data_o,
  output logic [NUM_BYTES-1:0]   datak_o,
`ifdef GEN1_SCR_STATS_EN
  output logic [15:0]            com_count_o,
`endif
  output logic [15:0]            lfsr_o
);

  localparam int unsigned DW = 8 * NUM_BYTES;
  localparam int unsigned LW = 16;
  localparam logic [7:0]    COM_SYM = 8'hBC;
  localparam logic [7:0]    SKP_SYM = 8'h1C;
  localparam logic [LW-1:0] TAPS    = 16'h0039;

  typedef struct packed {
    logic [7:0]    ks;
    logic [LW-1:0] lfsr;
  } adv_t;

  // Eight Galois steps: keystream bit b is the MSB before step b.
  function automatic adv_t lfsr_adv8(input logic [LW-1:0] s);
    adv_t r;
    r.ks   = '0;
    r.lfsr = s;
    for (int b = 0; b < 8; b++) begin
      r.ks[b] = r.lfsr[LW-1];
      r.lfsr  = {r.lfsr[LW-2:0], 1'b0} ^ (r.lfsr[LW-1] ? TAPS : 16'h0000);
    end
    return r;
  endfunction

  logic                 valid_q;
  logic                 valid_d;
  logic [DW-1:0]        data_q;
  logic [DW-1:0]        data_d;
  logic [NUM_BYTES-1:0] datak_q;
  logic [NUM_BYTES-1:0] datak_d;
  logic [LW-1:0]        lfsr_q;
  logic [LW-1:0]        lfsr_d;

  logic [NUM_BYTES-1:0] is_com_c;
  logic [NUM_BYTES-1:0] is_skp_c;
  logic [LW-1:0]        lfsr_run;
  logic [DW-1:0]        beat_c;
  adv_t                 adv_c;

  always_comb begin
    is_com_c = '0;
    is_skp_c = '0;
    for (int j = 0; j < NUM_BYTES; j++) begin
      is_com_c[j] = datak_i[j] && (data_i[8*j +: 8] == COM_SYM);
      is_skp_c[j] = datak_i[j] && (data_i[8*j +: 8] == SKP_SYM);
    end
  end

  // Unrolled byte chain: each byte sees the LFSR left by the byte before it.
  always_comb begin
    lfsr_run = lfsr_q;
    beat_c   = data_i;
    adv_c    = '0;
    for (int j = 0; j < NUM_BYTES; j++) begin
      adv_c = lfsr_adv8(lfsr_run);
      if (is_com_c[j]) begin
        lfsr_run = SEED;
      end else if (!is_skp_c[j]) begin
        if (!datak_i[j] && !training_sequence_i[j] && scramble_enable_i) begin
          beat_c[8*j +: 8] = data_i[8*j +: 8] ^ adv_c.ks;
        end
        lfsr_run = adv_c.lfsr;
      end
    end
  end

  always_comb begin
    valid_d = valid_i;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    datak_d = datak_q;
    if (valid_i) begin
      lfsr_d  = lfsr_run;
      data_d  = beat_c;
      datak_d = datak_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      datak_q <= '0;
      lfsr_q  <= SEED;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      datak_q <= datak_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign datak_o = datak_q;
  assign lfsr_o  = lfsr_q;

`ifdef GEN1_SCR_STATS_EN
  logic [15:0] com_cnt_q;
  logic [15:0] com_cnt_d;
  logic [16:0] com_sum_c;

  // Saturating count of accepted COM symbols; the 17-bit sum cannot wrap for NUM_BYTES <= 8.
  always_comb begin
    com_sum_c = {1'b0, com_cnt_q};
    if (valid_i) begin
      for (int j = 0; j < NUM_BYTES; j++) begin
        com_sum_c = com_sum_c + 17'(is_com_c[j]);
      end
    end
    com_cnt_d = com_sum_c[16] ? 16'hFFFF : com_sum_c[15:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      com_cnt_q <= '0;
    end else begin
      com_cnt_q <= com_cnt_d;
    end
  end

  assign com_count_o = com_cnt_q;
`endif

endmodule
